// File: rtl/i2cmb_cmd_sequencer.sv
// i2cmb_cmd_sequencer
//   Wishbone master that turns a simple byte-transaction request into the
//   register access sequence of the IICMB controller: core enable, Set Bus,
//   Start, address, data write/read, Stop. After every command it waits for
//   irq_i, reads CMDR back, and decodes the result. Read bytes are streamed
//   out on rd_data_o/rd_valid_o.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      request handshake (ready only in IDLE)
//   req_bus_i/addr_i/op_i/len_i  target bus, 7-bit address, 0=wr 1=rd, byte count
//   wr_data_i/wr_valid_i/wr_ready_o  write byte stream
//   rd_data_o/rd_valid_o         read byte stream (pulse, no backpressure)
//   done_o/status_o              end-of-transaction pulse and result code
//   busy_o                       transaction in progress
//   cyc_o/stb_o/we_o/adr_o/dat_o/dat_i/ack_i  Wishbone master port
//   irq_i                        controller command-done interrupt
module i2cmb_cmd_sequencer #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int NUM_I2C_BUSES = 1,
  parameter int LEN_WIDTH     = 6,
  parameter int IRQ_TIMEOUT   = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [((NUM_I2C_BUSES > 1) ? $clog2(NUM_I2C_BUSES) : 1)-1:0] req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic                     req_op_i,
  input  logic [LEN_WIDTH-1:0]     req_len_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  output logic [7:0]               rd_data_o,
  output logic                     rd_valid_o,
  output logic                     done_o,
  output logic [2:0]               status_o,
  output logic                     busy_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  localparam int BW = (NUM_I2C_BUSES > 1) ? $clog2(NUM_I2C_BUSES) : 1;
  localparam int TW = (IRQ_TIMEOUT > 1) ? $clog2(IRQ_TIMEOUT + 1) : 1;

  localparam logic [3:0] S_INIT       = 4'd0;
  localparam logic [3:0] S_IDLE       = 4'd1;
  localparam logic [3:0] S_SETBUS_DPR = 4'd2;
  localparam logic [3:0] S_SETBUS_CMD = 4'd3;
  localparam logic [3:0] S_START_CMD  = 4'd4;
  localparam logic [3:0] S_ADDR_DPR   = 4'd5;
  localparam logic [3:0] S_ADDR_CMD   = 4'd6;
  localparam logic [3:0] S_WDATA_DPR  = 4'd7;
  localparam logic [3:0] S_WDATA_CMD  = 4'd8;
  localparam logic [3:0] S_RD_CMD     = 4'd9;
  localparam logic [3:0] S_RD_DPR     = 4'd10;
  localparam logic [3:0] S_STOP_CMD   = 4'd11;
  localparam logic [3:0] S_WAIT       = 4'd12;
  localparam logic [3:0] S_DONE       = 4'd13;
  localparam logic [3:0] S_RECOV0     = 4'd14;
  localparam logic [3:0] S_RECOV1     = 4'd15;

  // Which command the WAIT state is waiting on.
  localparam logic [2:0] P_SETBUS = 3'd0;
  localparam logic [2:0] P_START  = 3'd1;
  localparam logic [2:0] P_ADDR   = 3'd2;
  localparam logic [2:0] P_WDATA  = 3'd3;
  localparam logic [2:0] P_RD     = 3'd4;
  localparam logic [2:0] P_STOP   = 3'd5;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_NAK     = 3'd1;
  localparam logic [2:0] ST_ARBLOST = 3'd2;
  localparam logic [2:0] ST_ERR     = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

  logic [3:0]           state;
  logic [2:0]           phase;
  logic [2:0]           res;
  logic [BW-1:0]        bus_q;
  logic [BW-1:0]        cur_bus;
  logic                 bus_valid;
  logic [6:0]           addr_q;
  logic                 op_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic [TW-1:0]        tmo;

  // Access the current state wants to issue.
  logic                     go;
  logic                     a_we;
  logic [WB_ADDR_WIDTH-1:0] a_adr;
  logic [WB_DATA_WIDTH-1:0] a_dat;
  logic                     launch;
  logic                     acked;
  logic                     last;

  assign last        = (cnt == LEN_WIDTH'(1));
  assign launch      = go && !cyc_o;
  assign acked       = cyc_o && ack_i;
  assign req_ready_o = (state == S_IDLE);
  assign wr_ready_o  = (state == S_WDATA_DPR) && !cyc_o && wr_valid_i;

  always_comb begin
    go    = 1'b0;
    a_we  = 1'b0;
    a_adr = '0;
    a_dat = '0;
    case (state)
      S_INIT, S_RECOV1: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_CSR; a_dat = WB_DATA_WIDTH'(8'hC0);
      end
      S_RECOV0: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_CSR; a_dat = '0;
      end
      S_SETBUS_DPR: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_DPR; a_dat = WB_DATA_WIDTH'(bus_q);
      end
      S_SETBUS_CMD: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_CMDR; a_dat = WB_DATA_WIDTH'(8'h06);
      end
      S_START_CMD: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_CMDR; a_dat = WB_DATA_WIDTH'(8'h04);
      end
      S_ADDR_DPR: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_DPR; a_dat = WB_DATA_WIDTH'({addr_q, op_q});
      end
      S_ADDR_CMD, S_WDATA_CMD: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_CMDR; a_dat = WB_DATA_WIDTH'(8'h01);
      end
      S_WDATA_DPR: begin
        // Stalls without a bus cycle until a write byte is offered.
        go = wr_valid_i; a_we = 1'b1; a_adr = A_DPR; a_dat = WB_DATA_WIDTH'(wr_data_i);
      end
      S_RD_CMD: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_CMDR;
        a_dat = last ? WB_DATA_WIDTH'(8'h03) : WB_DATA_WIDTH'(8'h02);
      end
      S_RD_DPR: begin
        go = 1'b1; a_adr = A_DPR;
      end
      S_STOP_CMD: begin
        go = 1'b1; a_we = 1'b1; a_adr = A_CMDR; a_dat = WB_DATA_WIDTH'(8'h05);
      end
      S_WAIT: begin
        go = irq_i; a_adr = A_CMDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_INIT;
      phase      <= P_SETBUS;
      res        <= ST_OK;
      bus_q      <= '0;
      cur_bus    <= '0;
      bus_valid  <= 1'b0;
      addr_q     <= '0;
      op_q       <= 1'b0;
      cnt        <= '0;
      tmo        <= '0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      status_o   <= ST_OK;
      busy_o     <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      rd_valid_o <= 1'b0;

      if (launch) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= a_we;
        adr_o <= a_adr;
        dat_o <= a_dat;
      end else if (acked) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        we_o  <= 1'b0;
        adr_o <= '0;
        dat_o <= '0;
      end

      case (state)
        S_INIT:       if (acked) state <= S_IDLE;
        S_IDLE: begin
          if (req_valid_i) begin
            bus_q  <= req_bus_i;
            addr_q <= req_addr_i;
            op_q   <= req_op_i;
            cnt    <= req_len_i;
            res    <= ST_OK;
            busy_o <= 1'b1;
            state  <= (bus_valid && (req_bus_i == cur_bus)) ? S_START_CMD : S_SETBUS_DPR;
          end
        end
        S_SETBUS_DPR: if (acked) state <= S_SETBUS_CMD;
        S_SETBUS_CMD: if (acked) begin phase <= P_SETBUS; tmo <= '0; state <= S_WAIT; end
        S_START_CMD:  if (acked) begin phase <= P_START;  tmo <= '0; state <= S_WAIT; end
        S_ADDR_DPR:   if (acked) state <= S_ADDR_CMD;
        S_ADDR_CMD:   if (acked) begin phase <= P_ADDR;   tmo <= '0; state <= S_WAIT; end
        S_WDATA_DPR:  if (acked) state <= S_WDATA_CMD;
        S_WDATA_CMD:  if (acked) begin phase <= P_WDATA;  tmo <= '0; state <= S_WAIT; end
        S_RD_CMD:     if (acked) begin phase <= P_RD;     tmo <= '0; state <= S_WAIT; end
        S_STOP_CMD:   if (acked) begin phase <= P_STOP;   tmo <= '0; state <= S_WAIT; end
        S_RD_DPR: begin
          if (acked) begin
            rd_data_o  <= dat_i[7:0];
            rd_valid_o <= 1'b1;
            cnt        <= cnt - LEN_WIDTH'(1);
            state      <= last ? S_STOP_CMD : S_RD_CMD;
          end
        end
        S_WAIT: begin
          if (acked) begin
            // Precedence AL > ERR > NAK > DON. A NAK seen on the Stop itself
            // does not replace the status already recorded.
            if (dat_i[5]) begin
              res       <= ST_ARBLOST;
              bus_valid <= 1'b0;
              state     <= S_DONE;
            end else if (dat_i[4]) begin
              res   <= ST_ERR;
              state <= S_DONE;
            end else if (dat_i[6] && (phase != P_STOP)) begin
              res   <= ST_NAK;
              state <= S_STOP_CMD;
            end else if (dat_i[7] || dat_i[6]) begin
              case (phase)
                P_SETBUS: begin
                  cur_bus   <= bus_q;
                  bus_valid <= 1'b1;
                  state     <= S_START_CMD;
                end
                P_START: state <= S_ADDR_DPR;
                P_ADDR: begin
                  if (cnt == '0)  state <= S_STOP_CMD;
                  else if (op_q)  state <= S_RD_CMD;
                  else            state <= S_WDATA_DPR;
                end
                P_WDATA: begin
                  cnt   <= cnt - LEN_WIDTH'(1);
                  state <= last ? S_STOP_CMD : S_WDATA_DPR;
                end
                P_RD:    state <= S_RD_DPR;
                default: state <= S_DONE;
              endcase
            end else begin
              // No status bit at all is treated as a controller error.
              res   <= ST_ERR;
              state <= S_DONE;
            end
          end else if (!cyc_o && !irq_i) begin
            if (tmo == TW'(IRQ_TIMEOUT - 1)) begin
              res       <= ST_TIMEOUT;
              bus_valid <= 1'b0;
              state     <= S_RECOV0;
            end else begin
              tmo <= tmo + TW'(1);
            end
          end
        end
        S_RECOV0: if (acked) state <= S_RECOV1;
        S_RECOV1: if (acked) state <= S_DONE;
        S_DONE: begin
          done_o   <= 1'b1;
          status_o <= res;
          busy_o   <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Scoreboard bench for i2cmb_cmd_sequencer with a behavioural IICMB slave.
module tb_i2cmb_cmd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [0:0] req_bus = '0;
  logic [6:0] req_addr = '0;
  logic       req_op = 1'b0;
  logic [5:0] req_len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic [2:0] status;
  logic       busy;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack = 1'b0;
  logic       irq = 1'b0;

  i2cmb_cmd_sequencer #(
    .WB_ADDR_WIDTH(2),
    .WB_DATA_WIDTH(8),
    .NUM_I2C_BUSES(2),
    .LEN_WIDTH(6),
    .IRQ_TIMEOUT(100)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_bus_i(req_bus), .req_addr_i(req_addr), .req_op_i(req_op), .req_len_i(req_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .done_o(done), .status_o(status), .busy_o(busy),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
  );

  typedef struct packed {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
  } wb_t;

  wb_t        exp_wb[$];
  logic [7:0] exp_rd[$];
  logic [2:0] exp_st[$];
  logic [7:0] stat_q[$];
  logic [7:0] rdb_q[$];
  logic [7:0] wq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit no_irq = 1'b0;

  // Controller model: one-cycle ack, irq a few cycles after each CMDR write,
  // CMDR read returns the queued status and clears irq, DPR read pops a byte.
  logic [7:0] pend = 8'h80;
  logic [7:0] sdat = 8'h00;
  int irq_dly = 0;
  assign dat_i = sdat;

  always @(posedge clk) begin
    if (rst) begin
      ack     <= 1'b0;
      irq     <= 1'b0;
      irq_dly <= 0;
    end else begin
      ack <= 1'b0;
      if (irq_dly > 0) begin
        irq_dly <= irq_dly - 1;
        if (irq_dly == 1 && !no_irq) irq <= 1'b1;
      end
      if (cyc && stb && !ack) begin
        ack <= 1'b1;
        if (we && adr == 2'd2) begin
          if (stat_q.size() > 0) pend <= stat_q.pop_front();
          else pend <= 8'h80;
          irq_dly <= 3;
        end else if (!we && adr == 2'd2) begin
          sdat <= pend;
          irq  <= 1'b0;
        end else if (!we && adr == 2'd1) begin
          if (rdb_q.size() > 0) sdat <= rdb_q.pop_front();
          else sdat <= 8'h00;
        end
      end
    end
  end

  // Write-byte source.
  always @(negedge clk) begin
    wr_valid = (wq.size() > 0);
    wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
  end
  always @(posedge clk) begin
    if (wr_valid && wr_ready && wq.size() > 0) void'(wq.pop_front());
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    wb_t g;
    wb_t e;
    logic [7:0] er;
    logic [2:0] es;
    if (cyc && ack) begin
      g = {we, adr, dat_o};
      n_cmp++;
      if (exp_wb.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected got we=%0b adr=%0d dat=%02h required no access", g.we, g.adr, g.dat);
      end else begin
        e = exp_wb.pop_front();
        if (g.we !== e.we || g.adr !== e.adr || (e.we && g.dat !== e.dat)) begin
          n_bad++;
          $display("FAIL wb_access got we=%0b adr=%0d dat=%02h required we=%0b adr=%0d dat=%02h",
                   g.we, g.adr, g.dat, e.we, e.adr, e.dat);
        end
      end
    end
    if (rd_valid) begin
      n_cmp++;
      if (exp_rd.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected got %02h required no byte", rd_data);
      end else begin
        er = exp_rd.pop_front();
        if (rd_data !== er) begin
          n_bad++;
          $display("FAIL rd_data got %02h required %02h", rd_data, er);
        end
      end
    end
    if (done) begin
      done_cnt++;
      n_cmp++;
      if (exp_st.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected got status %0d required no done", status);
      end else begin
        es = exp_st.pop_front();
        if (status !== es) begin
          n_bad++;
          $display("FAIL done_status got %0d required %0d", status, es);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic pw(input logic [1:0] a, input logic [7:0] d);
    exp_wb.push_back({1'b1, a, d});
  endtask

  task automatic pr(input logic [1:0] a);
    exp_wb.push_back({1'b0, a, 8'h00});
  endtask

  // CMDR write, the CMDR read that follows its irq, and the status it returns.
  task automatic pc(input logic [7:0] cmd, input logic [7:0] st);
    pw(2'd2, cmd);
    pr(2'd2);
    stat_q.push_back(st);
  endtask

  task automatic req(input logic b, input logic [6:0] a, input logic op, input logic [5:0] len);
    int ok;
    @(negedge clk);
    req_bus   = b;
    req_addr  = a;
    req_op    = op;
    req_len   = len;
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_accept got ready=0 required ready=1 within 300 cycles");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (ok == 1) chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done(input string name, output int cycles);
    int start;
    start  = done_cnt;
    cycles = 0;
    while (done_cnt == start && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    if (done_cnt == start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_done got no done required done within 3000 cycles", name);
    end
    repeat (3) @(negedge clk);
    chk({name, "_wb_drained"}, exp_wb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish before 50000 cycles");
    $fatal(1);
  end

  initial begin
    int cyc_n;
    int found;
    int d0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cyc", int'(cyc), 0);
    chk("rst_stb", int'(stb), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    pw(2'd0, 8'hC0);
    rst = 1'b0;

    // T1: write bus0, addr 0x22, two bytes
    wq.push_back(8'h11); wq.push_back(8'h22);
    pw(2'd1, 8'h00); pc(8'h06, 8'h80);
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h44); pc(8'h01, 8'h80);
    pw(2'd1, 8'h11); pc(8'h01, 8'h80);
    pw(2'd1, 8'h22); pc(8'h01, 8'h80);
    pc(8'h05, 8'h80);
    exp_st.push_back(3'd0);
    req(1'b0, 7'h22, 1'b0, 6'd2);
    wait_done("t1", cyc_n);
    chk("t1_busy_idle", int'(busy), 0);
    chk("t1_ready_idle", int'(req_ready), 1);

    // T2: read three bytes, same bus so no Set Bus
    rdb_q.push_back(8'd100); rdb_q.push_back(8'd101); rdb_q.push_back(8'd102);
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h45); pc(8'h01, 8'h80);
    pc(8'h02, 8'h80); pr(2'd1);
    pc(8'h02, 8'h80); pr(2'd1);
    pc(8'h03, 8'h80); pr(2'd1);
    pc(8'h05, 8'h80);
    exp_rd.push_back(8'h64); exp_rd.push_back(8'h65); exp_rd.push_back(8'h66);
    exp_st.push_back(3'd0);
    req(1'b0, 7'h22, 1'b1, 6'd3);
    wait_done("t2", cyc_n);

    // T3: NAK on address -> Stop, status NAK, held afterwards
    pc(8'h04, 8'h80);
    pw(2'd1, 8'hFE); pc(8'h01, 8'hC0);
    pc(8'h05, 8'h80);
    exp_st.push_back(3'd1);
    req(1'b0, 7'h7F, 1'b0, 6'd1);
    wait_done("t3", cyc_n);
    repeat (5) @(negedge clk);
    chk("t3_status_held", int'(status), 1);

    // T4: new bus1 needs Set Bus; a repeat on bus1 does not
    pw(2'd1, 8'h01); pc(8'h06, 8'h80);
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h20); pc(8'h01, 8'h80);
    pc(8'h05, 8'h80);
    exp_st.push_back(3'd0);
    req(1'b1, 7'h10, 1'b0, 6'd0);
    wait_done("t4a", cyc_n);
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h21); pc(8'h01, 8'h80);
    pc(8'h05, 8'h80);
    exp_st.push_back(3'd0);
    req(1'b1, 7'h10, 1'b1, 6'd0);
    wait_done("t4b", cyc_n);

    // Arbitration lost with every bit set: no Stop, bus-valid cleared
    pc(8'h04, 8'hF0);
    exp_st.push_back(3'd2);
    req(1'b1, 7'h10, 1'b0, 6'd0);
    wait_done("al", cyc_n);

    // ERR outranks NAK; Set Bus reissued since bus-valid was cleared
    pw(2'd1, 8'h01); pc(8'h06, 8'h80);
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h20); pc(8'h01, 8'h50);
    exp_st.push_back(3'd3);
    req(1'b1, 7'h10, 1'b0, 6'd0);
    wait_done("err", cyc_n);

    // NAK then an ERR on the Stop overrides the status
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h20); pc(8'h01, 8'hC0);
    pc(8'h05, 8'h90);
    exp_st.push_back(3'd3);
    req(1'b1, 7'h10, 1'b0, 6'd0);
    wait_done("stop_err", cyc_n);

    // T5: irq never arrives -> timeout, controller reset
    no_irq = 1'b1;
    pw(2'd2, 8'h04); stat_q.push_back(8'h80);
    pw(2'd0, 8'h00); pw(2'd0, 8'hC0);
    exp_st.push_back(3'd4);
    req(1'b1, 7'h10, 1'b0, 6'd0);
    wait_done("t5", cyc_n);
    chk("t5_timeout_window", int'(cyc_n >= 100 && cyc_n <= 130), 1);
    no_irq = 1'b0;
    pw(2'd1, 8'h01); pc(8'h06, 8'h80);
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h20); pc(8'h01, 8'h80);
    pc(8'h05, 8'h80);
    exp_st.push_back(3'd0);
    req(1'b1, 7'h10, 1'b0, 6'd0);
    wait_done("t5_after", cyc_n);

    // T6: reset while the first data byte write is being launched
    wq.push_back(8'hAA); wq.push_back(8'hBB);
    pw(2'd1, 8'h00); pc(8'h06, 8'h80);
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h44); pc(8'h01, 8'h80);
    pw(2'd1, 8'hAA);
    req(1'b0, 7'h22, 1'b0, 6'd2);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (cyc && we && adr == 2'd1 && dat_o == 8'hAA && !ack) begin found = 1; break; end
      @(negedge clk);
    end
    chk("t6_reached_data", found, 1);
    d0 = done_cnt;
    rst = 1'b1;
    exp_wb.delete(); stat_q.delete(); rdb_q.delete(); wq.delete(); exp_st.delete(); exp_rd.delete();
    pw(2'd0, 8'hC0);
    @(negedge clk);
    chk("t6_cyc_dropped", int'(cyc), 0);
    chk("t6_busy_cleared", int'(busy), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_init_seen", exp_wb.size(), 0);
    pw(2'd1, 8'h00); pc(8'h06, 8'h80);
    pc(8'h04, 8'h80);
    pw(2'd1, 8'h44); pc(8'h01, 8'h80);
    pc(8'h05, 8'h80);
    exp_st.push_back(3'd0);
    req(1'b0, 7'h22, 1'b0, 6'd0);
    wait_done("t6_after", cyc_n);

    chk("end_status_left", stat_q.size(), 0);
    chk("end_rd_left", exp_rd.size(), 0);
    chk("end_done_left", exp_st.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
